// File: rtl/m_mdu.sv
// Multiply/divide unit with HI/LO registers. Results are computed at issue,
// parked in pending registers, and committed after a fixed busy latency.
module m_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  md_op,
    input  logic        start,
    input  logic        cancel,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] md_out,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam int CMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    logic [CW-1:0] cnt, ld_cnt;
    logic [31:0]   p_hi, p_lo, res_hi, res_lo;
    logic [63:0]   prod_s, prod_u;
    logic [31:0]   quo_s, rem_s, quo_u, rem_u;
    logic          acc, arith;

    assign busy     = (cnt != '0);
    assign acc      = start & ~cancel & ~busy;
    assign md_stall = start & (md_op >= 4'd1) & (md_op <= 4'd8) & busy;
    assign md_out   = (md_op == OP_MFHI) ? hi : (md_op == OP_MFLO) ? lo : 32'd0;

    assign prod_s = 64'($signed(rs_val)) * 64'($signed(rt_val));
    assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};
    assign quo_s  = $signed(rs_val) / $signed(rt_val);
    assign rem_s  = $signed(rs_val) % $signed(rt_val);
    assign quo_u  = rs_val / rt_val;
    assign rem_u  = rs_val % rt_val;

    always_comb begin
        res_hi = hi;
        res_lo = lo;
        ld_cnt = '0;
        arith  = 1'b0;
        case (md_op)
            OP_MULT: begin
                {res_hi, res_lo} = prod_s;
                ld_cnt = CW'(MULT_CYCLES);
                arith  = 1'b1;
            end
            OP_MULTU: begin
                {res_hi, res_lo} = prod_u;
                ld_cnt = CW'(MULT_CYCLES);
                arith  = 1'b1;
            end
            OP_DIV: begin
                ld_cnt = CW'(DIV_CYCLES);
                arith  = 1'b1;
                // Divide by zero keeps HI/LO; the overflow case is pinned explicitly.
                if (rt_val == 32'd0) begin
                    res_hi = hi;
                    res_lo = lo;
                end else if (rs_val == 32'h8000_0000 && rt_val == 32'hFFFF_FFFF) begin
                    res_hi = 32'd0;
                    res_lo = 32'h8000_0000;
                end else begin
                    res_hi = rem_s;
                    res_lo = quo_s;
                end
            end
            OP_DIVU: begin
                ld_cnt = CW'(DIV_CYCLES);
                arith  = 1'b1;
                if (rt_val != 32'd0) begin
                    res_hi = rem_u;
                    res_lo = quo_u;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            p_hi <= '0;
            p_lo <= '0;
            hi   <= '0;
            lo   <= '0;
        end else if (busy) begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                hi <= p_hi;
                lo <= p_lo;
            end
        end else if (acc) begin
            if (arith) begin
                cnt  <= ld_cnt;
                p_hi <= res_hi;
                p_lo <= res_lo;
            end else if (md_op == OP_MTHI) begin
                hi <= rs_val;
            end else if (md_op == OP_MTLO) begin
                lo <= rs_val;
            end
        end
    end
endmodule
